// File: rtl/draw_pkg.sv
// Shared encodings for the shape-capture controller: draw modes, FSM states and
// the per-mode point requirement.
package draw_pkg;

    typedef enum logic [1:0] {
        MODE_FREEHAND = 2'd0,
        MODE_RECT     = 2'd1,
        MODE_LINE     = 2'd2,
        MODE_POLY     = 2'd3
    } draw_mode_e;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } cap_state_e;

    // Any mode index at or beyond MODE_POLY is a polygon and fills the whole buffer.
    function automatic int pts_needed(input int mode, input int max_pts);
        if (mode == int'(MODE_FREEHAND)) begin
            return 0;
        end else if (mode <= int'(MODE_LINE)) begin
            return 2;
        end else begin
            return max_pts;
        end
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one already-debounced button level.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/shape_capture_ctrl.sv
// Draw-mode controller: cycles modes, captures cursor points, hands the finished
// shape to the rasteriser over valid/ready. Optional undo button: SHAPE_UNDO_EN.
module shape_capture_ctrl
    import draw_pkg::*;
#(
    parameter  int COORD_W   = 8,
    parameter  int NUM_MODES = 4,
    parameter  int MAX_PTS   = 3,
    localparam int MODE_W    = $clog2(NUM_MODES),
    localparam int IDX_W     = $clog2(MAX_PTS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_mode,
    input  logic                       btn_point,
    input  logic                       btn_cancel,
    input  logic                       btn_undo,
    input  logic [COORD_W-1:0]         x_pos,
    input  logic [COORD_W-1:0]         y_pos,
    output logic [MODE_W-1:0]          mode,
    output logic [IDX_W-1:0]           pt_count,
    output logic [MAX_PTS*COORD_W-1:0] pts_x,
    output logic [MAX_PTS*COORD_W-1:0] pts_y,
    output logic                       shape_valid,
    input  logic                       shape_ready
);

    localparam int BTN_MODE   = 0;
    localparam int BTN_POINT  = 1;
    localparam int BTN_CANCEL = 2;
`ifdef SHAPE_UNDO_EN
    localparam int BTN_UNDO   = 3;
    localparam int NUM_BTN    = 4;
`else
    localparam int NUM_BTN    = 3;
`endif

    logic [NUM_BTN-1:0] btn_lvl;
    logic [NUM_BTN-1:0] btn_rise;
    logic               mode_rise;
    logic               point_rise;
    logic               cancel_rise;
    logic               undo_rise;

    assign btn_lvl[BTN_MODE]   = btn_mode;
    assign btn_lvl[BTN_POINT]  = btn_point;
    assign btn_lvl[BTN_CANCEL] = btn_cancel;

`ifdef SHAPE_UNDO_EN
    assign btn_lvl[BTN_UNDO] = btn_undo;
    assign undo_rise         = btn_rise[BTN_UNDO];
`else
    logic unused_btn_undo;
    assign unused_btn_undo = btn_undo;
    assign undo_rise       = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_edge u_edge (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn_lvl[gi]),
                .rise (btn_rise[gi])
            );
        end
    endgenerate

    assign mode_rise   = btn_rise[BTN_MODE];
    assign point_rise  = btn_rise[BTN_POINT];
    assign cancel_rise = btn_rise[BTN_CANCEL];

    cap_state_e         state_q, state_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   need;
    logic               wr_en;
    logic [COORD_W-1:0] pts_x_q [MAX_PTS];
    logic [COORD_W-1:0] pts_y_q [MAX_PTS];

    always_comb begin
        need = IDX_W'(pts_needed(int'(mode_q), MAX_PTS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // Edges in priority order cancel > mode > undo > point; lower ones are dropped.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (cancel_rise) begin
                    cnt_d = '0;
                end else if (mode_rise) begin
                    mode_d = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
                    cnt_d  = '0;
                end else if (undo_rise) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (point_rise && (need != '0)) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == need - 1'b1) begin
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (shape_ready) begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_comb begin
        shape_valid = (state_q == ST_PENDING);
        mode        = mode_q;
        pt_count    = cnt_q;
    end

    // Each slot loads only when the write pointer lands on it; old data survives cancel/undo.
    generate
        for (gi = 0; gi < MAX_PTS; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    pts_x_q[gi] <= '0;
                    pts_y_q[gi] <= '0;
                end else if (wr_en && (cnt_q == IDX_W'(gi))) begin
                    pts_x_q[gi] <= x_pos;
                    pts_y_q[gi] <= y_pos;
                end
            end

            assign pts_x[gi*COORD_W +: COORD_W] = pts_x_q[gi];
            assign pts_y[gi*COORD_W +: COORD_W] = pts_y_q[gi];
        end
    endgenerate

endmodule
